// File: rtl/shift_sequencer_if.sv
// rtl/shift_sequencer_if.sv - request/result handshake bundle for the shift sequencer
//
// Purpose:
//   Groups the issue-side request channel and the writeback-side result
//   channel of shift_sequencer into one interface.
//
// Signals:
//   inValid      request valid (issue logic -> sequencer)
//   inReady      sequencer can accept a request
//   control      00 SHL, 01 SHR, 10 SAR, 11 ROL-through-carry
//   carryIn      initial carry bit
//   numToShift   operand, DataLength bits
//   shiftAmount  unsigned step count, DataLength bits
//   outValid     result valid (sequencer -> writeback)
//   outReady     consumer accepts result
//   result       shifted data, DataLength bits
//   carryOut     final carry
//
// Modports:
//   master  issue/writeback side (drives requests, accepts results)
//   slave   the sequencer itself

`timescale 1ns/1ps

interface shift_sequencer_if #(
  parameter int DataLength = 4
);

  logic                  inValid;
  logic                  inReady;
  logic [1:0]            control;
  logic                  carryIn;
  logic [DataLength-1:0] numToShift;
  logic [DataLength-1:0] shiftAmount;

  logic                  outValid;
  logic                  outReady;
  logic [DataLength-1:0] result;
  logic                  carryOut;

  modport master (
    output inValid,
    output control,
    output carryIn,
    output numToShift,
    output shiftAmount,
    output outReady,
    input  inReady,
    input  outValid,
    input  result,
    input  carryOut
  );

  modport slave (
    input  inValid,
    input  control,
    input  carryIn,
    input  numToShift,
    input  shiftAmount,
    input  outReady,
    output inReady,
    output outValid,
    output result,
    output carryOut
  );

endinterface

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - iterative one-bit-per-cycle shifter with valid/ready handshakes
//
// Purpose:
//   Multi-cycle replacement for a combinational barrel shifter on the ALU
//   shift path. A request is captured into a {carry, data} register and one
//   single-bit step is applied per clock until the step counter is exhausted,
//   then the result is presented until writeback takes it.
//
// Ports:
//   clk    single clock, all state updates on the rising edge
//   rstN   asynchronous active-low reset
//   flush  synchronous abort; returns to IDLE, keeps register contents
//   bus    shift_sequencer_if.slave (request and result channels)
//   busy   high while in SHIFT or DONE
//
// Operations (M = DataLength-1), applied once per step on {c, d}:
//   00 SHL : c <= d[M], d <= {d[M-1:0], 0}
//   01 SHR : c <= d[0], d <= {0, d[M:1]}
//   10 SAR : c <= d[0], d <= {d[M], d[M:1]}
//   11 ROL : c <= d[M], d <= {d[M-1:0], c}   (rotate through carry)
//
// Build option:
//   SHIFT_EARLY_EXIT_EN - when defined, the step count loaded at acceptance
//   is reduced to the smallest count giving a bit-identical result:
//   min(amount, DataLength+1) for SHL/SHR/SAR, amount mod (DataLength+1)
//   for ROL. Undefined, the raw amount is iterated.

`timescale 1ns/1ps

module shift_sequencer #(
  parameter int DataLength = 4
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              flush,
  shift_sequencer_if.slave  bus,
  output logic              busy
);

  localparam int M = DataLength - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OpShl = 2'b00;
  localparam logic [1:0] OpShr = 2'b01;
  localparam logic [1:0] OpSar = 2'b10;
  localparam logic [1:0] OpRol = 2'b11;

  state_t                state;
  state_t                state_next;

  logic [1:0]            op;
  logic                  c;
  logic [DataLength-1:0] d;
  logic [DataLength-1:0] cnt;

  logic                  accept;
  logic                  step;
  logic [DataLength-1:0] load_cnt;
  logic                  step_c;
  logic [DataLength-1:0] step_d;

  // ---------------------------------------------------------------------------
  // Step count loaded at acceptance
  // ---------------------------------------------------------------------------
`ifdef SHIFT_EARLY_EXIT_EN
  // The {c, d} ring is DataLength+1 bits wide, so a rotate repeats with that
  // period. The plain shifts are fully saturated (data and carry) after
  // DataLength+1 steps, so any further steps cannot change the outcome.
  localparam logic [DataLength:0] Ring = (DataLength + 1)'(DataLength + 1);

  logic [DataLength:0] amt_ext;

  always_comb begin
    amt_ext  = {1'b0, bus.shiftAmount};
    load_cnt = bus.shiftAmount;
    if (bus.control == OpRol) begin
      load_cnt = DataLength'(amt_ext % Ring);
    end else if (amt_ext > Ring) begin
      load_cnt = DataLength'(Ring);
    end
  end
`else
  always_comb begin
    load_cnt = bus.shiftAmount;
  end
`endif

  // ---------------------------------------------------------------------------
  // Single-bit step on {c, d}
  // ---------------------------------------------------------------------------
  always_comb begin
    step_c = c;
    step_d = d;
    case (op)
      OpShl: begin
        step_c = d[M];
        step_d = {d[M-1:0], 1'b0};
      end
      OpShr: begin
        step_c = d[0];
        step_d = {1'b0, d[M:1]};
      end
      OpSar: begin
        step_c = d[0];
        step_d = {d[M], d[M:1]};
      end
      OpRol: begin
        step_c = d[M];
        step_d = {d[M-1:0], c};
      end
      default: begin
        step_c = c;
        step_d = d;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // ---------------------------------------------------------------------------
  // Handshake outputs depend only on the state, so the result channel is
  // stable for as long as writeback stalls. flush overrides every transition
  // and also blocks acceptance in IDLE.
  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    step         = 1'b0;
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    busy         = 1'b0;

    case (state)
      IDLE: begin
        bus.inReady = 1'b1;
        if (!flush && bus.inValid) begin
          accept = 1'b1;
          if (load_cnt == '0) begin
            state_next = DONE;
          end else begin
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        busy = 1'b1;
        if (!flush) begin
          step = 1'b1;
          if (cnt == DataLength'(1)) begin
            state_next = DONE;
          end
        end
      end

      DONE: begin
        busy         = 1'b1;
        bus.outValid = 1'b1;
        if (!flush && bus.outReady) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      state_next = IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // On flush neither accept nor step is raised, so {c, d} simply holds.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op  <= 2'b00;
      c   <= 1'b0;
      d   <= '0;
      cnt <= '0;
    end else if (accept) begin
      op  <= bus.control;
      c   <= bus.carryIn;
      d   <= bus.numToShift;
      cnt <= load_cnt;
    end else if (step) begin
      c   <= step_c;
      d   <= step_d;
      cnt <= cnt - DataLength'(1);
    end
  end

  assign bus.result   = d;
  assign bus.carryOut = c;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer

`timescale 1ns/1ps

module tb_shift_sequencer;

  localparam int DL = 4;

`ifdef SHIFT_EARLY_EXIT_EN
  localparam bit EarlyExit = 1'b1;
`else
  localparam bit EarlyExit = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rstN  = 1'b0;
  logic flush = 1'b0;
  logic busy;

  int total = 0;
  int bad   = 0;

  shift_sequencer_if #(.DataLength(DL)) bus ();

  shift_sequencer #(.DataLength(DL)) dut (
    .clk   (clk),
    .rstN  (rstN),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a request on a falling edge; it is accepted on the next rising edge.
  task automatic issue(input logic [1:0] op, input logic cin,
                       input logic [3:0] num, input logic [3:0] amt);
    @(negedge clk);
    bus.inValid     = 1'b1;
    bus.control     = op;
    bus.carryIn     = cin;
    bus.numToShift  = num;
    bus.shiftAmount = amt;
    @(posedge clk);
    #1 bus.inValid = 1'b0;
  endtask

  // Counts rising edges after the acceptance edge until outValid is seen.
  task automatic wait_done(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.outValid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic consume();
    bus.outReady = 1'b1;
    @(posedge clk);
    #1 bus.outReady = 1'b0;
    @(negedge clk);
  endtask

  // Latency is counted as in the request timing: edges from the cycle the
  // request is presented, i.e. 1 + steps executed.
  task automatic run(input string tag, input logic [1:0] op, input logic cin,
                     input logic [3:0] num, input logic [3:0] amt,
                     input logic [3:0] exp_res, input logic exp_c, input int exp_lat);
    int n;
    issue(op, cin, num, amt);
    wait_done(n);
    chk({tag, "_lat"},      n + 1,        exp_lat);
    chk({tag, "_outvalid"}, bus.outValid, 1'b1);
    chk({tag, "_result"},   bus.result,   exp_res);
    chk({tag, "_carry"},    bus.carryOut, exp_c);
    chk({tag, "_busy"},     busy,         1'b1);
    chk({tag, "_inready"},  bus.inReady,  1'b0);
    consume();
    chk({tag, "_idle_ov"},  bus.outValid, 1'b0);
    chk({tag, "_idle_ir"},  bus.inReady,  1'b1);
  endtask

  initial begin
    int n;
    int seen;

    bus.inValid     = 1'b0;
    bus.control     = 2'b00;
    bus.carryIn     = 1'b0;
    bus.numToShift  = '0;
    bus.shiftAmount = '0;
    bus.outReady    = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    chk("rst_inready",  bus.inReady,  1'b1);
    chk("rst_outvalid", bus.outValid, 1'b0);
    chk("rst_busy",     busy,         1'b0);
    chk("rst_result",   bus.result,   4'b0000);
    chk("rst_carry",    bus.carryOut, 1'b0);

    // Basic operations
    run("shl1",  2'b00, 1'b0, 4'b1011, 4'd1, 4'b0110, 1'b1, 2);
    run("sar2",  2'b10, 1'b0, 4'b1000, 4'd2, 4'b1110, 1'b0, 3);
    run("shr2",  2'b01, 1'b0, 4'b1000, 4'd2, 4'b0010, 1'b0, 3);
    run("rol5",  2'b11, 1'b0, 4'b1001, 4'd5, 4'b1001, 1'b0, EarlyExit ? 1 : 6);
    run("rolc1", 2'b11, 1'b1, 4'b1000, 4'd1, 4'b0001, 1'b1, 2);

    // Amounts beyond the width saturate
    run("sar7",  2'b10, 1'b0, 4'b1000, 4'd7,  4'b1111, 1'b1, EarlyExit ? 6 : 8);
    run("shl15", 2'b00, 1'b1, 4'b1111, 4'd15, 4'b0000, 1'b0, EarlyExit ? 6 : 16);

    // Zero amount, then writeback stall with a competing request
    issue(2'b01, 1'b1, 4'b0101, 4'd0);
    wait_done(n);
    chk("amt0_lat", n + 1, 1);
    for (int i = 0; i < 3; i++) begin
      bus.inValid     = 1'b1;
      bus.control     = 2'b00;
      bus.carryIn     = 1'b0;
      bus.numToShift  = 4'b1111;
      bus.shiftAmount = 4'd1;
      @(posedge clk);
      @(negedge clk);
      chk("hold_result",   bus.result,   4'b0101);
      chk("hold_carry",    bus.carryOut, 1'b1);
      chk("hold_outvalid", bus.outValid, 1'b1);
      chk("hold_inready",  bus.inReady,  1'b0);
    end
    bus.inValid = 1'b0;
    consume();
    chk("hold_rel_ov",     bus.outValid, 1'b0);
    chk("hold_rel_ir",     bus.inReady,  1'b1);
    chk("hold_rel_busy",   busy,         1'b0);
    chk("hold_rel_result", bus.result,   4'b0101);

    // Flush during SHIFT: abort, keep partial register contents
    issue(2'b00, 1'b0, 4'b0001, 4'd7);
    repeat (2) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_outvalid", bus.outValid, 1'b0);
    chk("flush_busy",     busy,         1'b0);
    chk("flush_inready",  bus.inReady,  1'b1);
    chk("flush_result",   bus.result,   4'b0100);
    chk("flush_carry",    bus.carryOut, 1'b0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.outValid) seen++;
    end
    chk("flush_no_pulse", seen, 0);

    // Flush in IDLE blocks acceptance
    @(negedge clk);
    flush           = 1'b1;
    bus.inValid     = 1'b1;
    bus.control     = 2'b00;
    bus.carryIn     = 1'b1;
    bus.numToShift  = 4'b0011;
    bus.shiftAmount = 4'd0;
    @(posedge clk);
    #1;
    flush       = 1'b0;
    bus.inValid = 1'b0;
    @(negedge clk);
    chk("iflush_busy",     busy,         1'b0);
    chk("iflush_outvalid", bus.outValid, 1'b0);
    chk("iflush_result",   bus.result,   4'b0100);
    chk("iflush_carry",    bus.carryOut, 1'b0);

    // Asynchronous reset in the middle of SHIFT
    issue(2'b00, 1'b1, 4'b0111, 4'd7);
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    chk("arst_inready",  bus.inReady,  1'b1);
    chk("arst_outvalid", bus.outValid, 1'b0);
    chk("arst_busy",     busy,         1'b0);
    chk("arst_result",   bus.result,   4'b0000);
    chk("arst_carry",    bus.carryOut, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.outValid) seen++;
    end
    chk("arst_no_result", seen, 0);

    // Still operational after reset
    run("post_shr1", 2'b01, 1'b0, 4'b0011, 4'd1, 4'b0001, 1'b1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
